// File: rtl/msxbus_pkg.sv
// Shared types and constants for the MSX cartridge-bus initiator.
// MSXBUS_MASTER_TIMEOUT_EN widens the shared counter so it can also time the wait phase.
package msxbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_WAIT,
    ST_HOLD
  } state_e;

`ifdef MSXBUS_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = 12;
`else
  localparam int unsigned CNT_W = 6;
`endif

  localparam logic        STROBE_OFF    = 1'b1;
  localparam logic [15:0] ADR_IDLE      = 16'h0000;
  localparam logic [7:0]  DATA_IDLE     = 8'h00;
  localparam logic [7:0]  RDATA_TIMEOUT = 8'hFF;

  // Access type latched at request acceptance.
  typedef struct packed {
    logic write;
    logic io;
    logic sltsl;
  } req_t;

endpackage

// File: rtl/ip_msxbus_master_if.sv
// Request and cartridge-bus signals of the MSX bus initiator.
// master = the initiator itself, slave = the host/cartridge side.
interface ip_msxbus_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_io;
  logic        req_sltsl;
  logic [15:0] req_address;
  logic [7:0]  req_wdata;
  logic [7:0]  rdata;
  logic        rdata_en;
  logic        timeout;
  logic [15:0] bus_adr;
  logic [7:0]  bus_o_data;
  logic        bus_data_oe;
  logic [7:0]  bus_i_data;
  logic        n_sltsl;
  logic        n_mereq;
  logic        n_ioreq;
  logic        n_rd;
  logic        n_wr;
  logic        bus_wait;

  modport master (
    input  req_valid, req_write, req_io, req_sltsl, req_address, req_wdata,
    input  bus_i_data, bus_wait,
    output req_ready, rdata, rdata_en, timeout,
    output bus_adr, bus_o_data, bus_data_oe, n_sltsl, n_mereq, n_ioreq, n_rd, n_wr
  );

  modport slave (
    output req_valid, req_write, req_io, req_sltsl, req_address, req_wdata,
    output bus_i_data, bus_wait,
    input  req_ready, rdata, rdata_en, timeout,
    input  bus_adr, bus_o_data, bus_data_oe, n_sltsl, n_mereq, n_ioreq, n_rd, n_wr
  );
endinterface

// File: rtl/ip_msxbus_master_sync2.sv
// Two-flop synchronizer for the asynchronous cartridge wait line.
module ip_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ip_msxbus_master.sv
// MSX cartridge-bus initiator: single-beat memory/I-O requests to Z80-style strobe cycles.
// Optional build macro MSXBUS_MASTER_TIMEOUT_EN bounds the wait phase with TIMEOUT_CYCLES.
module ip_msxbus_master
  import msxbus_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES  = 4,
  parameter int unsigned STROBE_CYCLES = 15,
  parameter int unsigned HOLD_CYCLES   = 4
`ifdef MSXBUS_MASTER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 4095
`endif
) (
  input  logic                clk,
  input  logic                reset,
  ip_msxbus_master_if.master  mb
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  req_t             req_q;
  logic             req_ready_q;
  logic [7:0]       rdata_q;
  logic             rdata_en_q;
  logic [15:0]      adr_q;
  logic [7:0]       odata_q;
  logic             oe_q;
  logic             n_sltsl_q, n_mereq_q, n_ioreq_q, n_rd_q, n_wr_q;
  logic             wait_s;
  logic             release_c;
  logic             abort_c;

  ip_sync2 u_wait_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (mb.bus_wait),
    .q_o   (wait_s)
  );

  // Strobe phase ends normally: minimum width reached with wait low, or wait released.
  assign release_c = ((state_q == ST_STROBE) && (cnt_q == '0) && !wait_s) ||
                     ((state_q == ST_WAIT) && !wait_s);

`ifdef MSXBUS_MASTER_TIMEOUT_EN
  logic timeout_q;
  assign abort_c    = (state_q == ST_WAIT) && wait_s && (cnt_q == '0);
  assign mb.timeout = timeout_q;
`else
  assign abort_c    = 1'b0;
  assign mb.timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      req_ready_q <= 1'b1;
      rdata_q     <= DATA_IDLE;
      rdata_en_q  <= 1'b0;
      adr_q       <= ADR_IDLE;
      odata_q     <= DATA_IDLE;
      oe_q        <= 1'b0;
      n_sltsl_q   <= STROBE_OFF;
      n_mereq_q   <= STROBE_OFF;
      n_ioreq_q   <= STROBE_OFF;
      n_rd_q      <= STROBE_OFF;
      n_wr_q      <= STROBE_OFF;
`ifdef MSXBUS_MASTER_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      rdata_en_q <= 1'b0;
`ifdef MSXBUS_MASTER_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (mb.req_valid) begin
            req_q       <= '{write: mb.req_write, io: mb.req_io, sltsl: mb.req_sltsl};
            adr_q       <= mb.req_address;
            if (mb.req_write) begin
              odata_q <= mb.req_wdata;
              oe_q    <= 1'b1;
            end
            req_ready_q <= 1'b0;
            cnt_q       <= CNT_W'(SETUP_CYCLES - 1);
            state_q     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_q == '0) begin
            // /SLTSL only accompanies memory cycles that request it.
            n_mereq_q <= req_q.io;
            n_ioreq_q <= ~req_q.io;
            n_sltsl_q <= req_q.io | ~req_q.sltsl;
            n_rd_q    <= req_q.write;
            n_wr_q    <= ~req_q.write;
            cnt_q     <= CNT_W'(STROBE_CYCLES - 1);
            state_q   <= ST_STROBE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_STROBE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (wait_s) begin
            state_q <= ST_WAIT;
`ifdef MSXBUS_MASTER_TIMEOUT_EN
            cnt_q   <= CNT_W'(TIMEOUT_CYCLES - 1);
`endif
          end
        end
        ST_WAIT: begin
`ifdef MSXBUS_MASTER_TIMEOUT_EN
          if (wait_s && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
`endif
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            oe_q        <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Leaving the strobe phase: release every strobe together and report read data.
      if (release_c || abort_c) begin
        n_sltsl_q <= STROBE_OFF;
        n_mereq_q <= STROBE_OFF;
        n_ioreq_q <= STROBE_OFF;
        n_rd_q    <= STROBE_OFF;
        n_wr_q    <= STROBE_OFF;
        cnt_q     <= CNT_W'(HOLD_CYCLES - 1);
        state_q   <= ST_HOLD;
        if (!req_q.write) begin
          rdata_q    <= abort_c ? RDATA_TIMEOUT : mb.bus_i_data;
          rdata_en_q <= ~abort_c;
        end
`ifdef MSXBUS_MASTER_TIMEOUT_EN
        timeout_q <= abort_c;
`endif
      end
    end
  end

  assign mb.req_ready   = req_ready_q;
  assign mb.rdata       = rdata_q;
  assign mb.rdata_en    = rdata_en_q;
  assign mb.bus_adr     = adr_q;
  assign mb.bus_o_data  = odata_q;
  assign mb.bus_data_oe = oe_q;
  assign mb.n_sltsl     = n_sltsl_q;
  assign mb.n_mereq     = n_mereq_q;
  assign mb.n_ioreq     = n_ioreq_q;
  assign mb.n_rd        = n_rd_q;
  assign mb.n_wr        = n_wr_q;

endmodule

// File: tb/tb_ip_msxbus_master.sv
// Bench for ip_msxbus_master: per-access strobe/timing checks plus a read-data scoreboard.
// Define MSXBUS_MASTER_TIMEOUT_EN to also exercise the wait timeout (TIMEOUT_CYCLES=100).
module tb_ip_msxbus_master;

  localparam int SETUP  = 4;
  localparam int STROBE = 15;
  localparam int HOLD   = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   en_cnt = 0;
  int   to_cnt = 0;
  logic [7:0] exp_q[$];

  ip_msxbus_master_if mb();

  ip_msxbus_master #(
    .SETUP_CYCLES  (SETUP),
    .STROBE_CYCLES (STROBE),
    .HOLD_CYCLES   (HOLD)
`ifdef MSXBUS_MASTER_TIMEOUT_EN
    , .TIMEOUT_CYCLES (100)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mb    (mb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Read-data scoreboard and pulse counters.
  always @(negedge clk) begin
    if (mb.rdata_en === 1'b1) begin
      en_cnt++;
      if (exp_q.size() == 0) chk("rdata_en_unexpected", 32'd1, 32'd0);
      else chk("rdata", 32'(mb.rdata), 32'(exp_q.pop_front()));
    end
    if (mb.timeout === 1'b1) to_cnt++;
  end

  // One access, started and finished on a falling edge; profiles the strobes cycle by cycle.
  task automatic access(input bit wr, input bit io, input bit sl, input logic [15:0] adr,
                        input logic [7:0] wd, input logic [7:0] bd, input bit keep,
                        input int exp_lo, input int exp_en, input int exp_to);
    int busy = 0, pre = 0, post = 0, lo = 0, en0, to0;
    int rd_lo = 0, wr_lo = 0, mq_lo = 0, iq_lo = 0, sl_lo = 0, oe_hi = 0, adr_bad = 0, od_bad = 0;
    int exp_busy;
    bit seen = 0;
    exp_busy = SETUP + exp_lo + HOLD;
    mb.req_write   = wr;
    mb.req_io      = io;
    mb.req_sltsl   = sl;
    mb.req_address = adr;
    mb.req_wdata   = wd;
    mb.bus_i_data  = bd;
    mb.req_valid   = 1'b1;
    if (!wr && exp_en == 1) exp_q.push_back(bd);
    chk("ready_before_accept", 32'(mb.req_ready), 32'd1);
    en0 = en_cnt;
    to0 = to_cnt;
    @(posedge clk);
    @(negedge clk);
    if (!keep) mb.req_valid = 1'b0;
    while (mb.req_ready !== 1'b1 && busy < 5000) begin
      busy++;
      if (!(mb.n_rd && mb.n_wr && mb.n_mereq && mb.n_ioreq && mb.n_sltsl)) begin
        seen = 1;
        lo++;
      end else if (!seen) pre++;
      else post++;
      if (!mb.n_rd)    rd_lo++;
      if (!mb.n_wr)    wr_lo++;
      if (!mb.n_mereq) mq_lo++;
      if (!mb.n_ioreq) iq_lo++;
      if (!mb.n_sltsl) sl_lo++;
      if (mb.bus_adr !== adr) adr_bad++;
      if (mb.bus_data_oe) begin
        oe_hi++;
        if (mb.bus_o_data !== wd) od_bad++;
      end
      @(negedge clk);
    end
    chk("busy_cycles", 32'(busy), 32'(exp_busy));
    chk("setup_cycles", 32'(pre), 32'(SETUP));
    chk("strobe_cycles", 32'(lo), 32'(exp_lo));
    chk("hold_cycles", 32'(post), 32'(HOLD));
    chk("n_rd_low", 32'(rd_lo), 32'(wr ? 0 : exp_lo));
    chk("n_wr_low", 32'(wr_lo), 32'(wr ? exp_lo : 0));
    chk("n_mereq_low", 32'(mq_lo), 32'(io ? 0 : exp_lo));
    chk("n_ioreq_low", 32'(iq_lo), 32'(io ? exp_lo : 0));
    chk("n_sltsl_low", 32'(sl_lo), 32'((!io && sl) ? exp_lo : 0));
    chk("oe_cycles", 32'(oe_hi), 32'(wr ? exp_busy : 0));
    chk("adr_stable", 32'(adr_bad), 32'd0);
    chk("odata_stable", 32'(od_bad), 32'd0);
    chk("oe_after", 32'(mb.bus_data_oe), 32'd0);
    chk("rdata_en_count", 32'(en_cnt - en0), 32'(exp_en));
    chk("timeout_count", 32'(to_cnt - to0), 32'(exp_to));
  endtask

  initial begin
    mb.req_valid   = 1'b0;
    mb.req_write   = 1'b0;
    mb.req_io      = 1'b0;
    mb.req_sltsl   = 1'b0;
    mb.req_address = 16'h0000;
    mb.req_wdata   = 8'h00;
    mb.bus_i_data  = 8'h00;
    mb.bus_wait    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_strobes", 32'({mb.n_sltsl, mb.n_mereq, mb.n_ioreq, mb.n_rd, mb.n_wr}), 32'h1F);
    chk("rst_adr", 32'(mb.bus_adr), 32'h0);
    chk("rst_odata", 32'(mb.bus_o_data), 32'h0);
    chk("rst_oe", 32'(mb.bus_data_oe), 32'h0);
    chk("rst_rdata", 32'(mb.rdata), 32'h0);
    chk("rst_rdata_en", 32'(mb.rdata_en), 32'h0);
    chk("rst_timeout", 32'(mb.timeout), 32'h0);
    chk("rst_ready", 32'(mb.req_ready), 32'h1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic memory and I/O cycles
    access(1'b0, 1'b0, 1'b1, 16'h4000, 8'h00, 8'h5A, 1'b0, STROBE, 1, 0);
    access(1'b1, 1'b1, 1'b1, 16'h0001, 8'hC3, 8'h00, 1'b0, STROBE, 0, 0);
    access(1'b0, 1'b0, 1'b0, 16'hFFFF, 8'h00, 8'h00, 1'b0, STROBE, 1, 0);
    access(1'b0, 1'b1, 1'b0, 16'h00A8, 8'h00, 8'h81, 1'b0, STROBE, 1, 0);
    chk("rdata_held", 32'(mb.rdata), 32'h81);
    repeat (3) @(negedge clk);

    // Back-to-back with req_valid held: second accept on the cycle ready rises
    access(1'b1, 1'b0, 1'b1, 16'h7FFF, 8'h3A, 8'h00, 1'b1, STROBE, 0, 0);
    access(1'b0, 1'b0, 1'b1, 16'h4001, 8'h00, 8'hE7, 1'b0, STROBE, 1, 0);
    repeat (2) @(negedge clk);

    // Wait held 40 cycles from strobe assertion; data changes while waiting
    fork
      access(1'b0, 1'b0, 1'b1, 16'h5000, 8'h00, 8'h3C, 1'b0, 40 + 2 + 1, 1, 0);
      begin
        int k = 0;
        while (mb.n_rd !== 1'b0 && k < 100) begin
          @(negedge clk);
          k++;
        end
        mb.bus_i_data = 8'hA5;
        mb.bus_wait   = 1'b1;
        repeat (40) @(negedge clk);
        mb.bus_i_data = 8'h3C;
        mb.bus_wait   = 1'b0;
      end
    join
    repeat (2) @(negedge clk);

    // Wait pulse that ends during setup does not stretch the strobe
    mb.bus_wait = 1'b1;
    fork
      access(1'b0, 1'b1, 1'b0, 16'h0099, 8'h00, 8'h42, 1'b0, STROBE, 1, 0);
      begin
        repeat (3) @(negedge clk);
        mb.bus_wait = 1'b0;
      end
    join
    repeat (2) @(negedge clk);

    // Reset in the middle of a write strobe
    begin
      int en0;
      en0 = en_cnt;
      mb.req_write   = 1'b1;
      mb.req_io      = 1'b0;
      mb.req_sltsl   = 1'b1;
      mb.req_address = 16'h8000;
      mb.req_wdata   = 8'h77;
      mb.req_valid   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      mb.req_valid = 1'b0;
      repeat (SETUP + 3) @(negedge clk);
      chk("rstmid_wr_low", 32'(mb.n_wr), 32'd0);
      chk("rstmid_oe_on", 32'(mb.bus_data_oe), 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("rstmid_strobes", 32'({mb.n_sltsl, mb.n_mereq, mb.n_ioreq, mb.n_rd, mb.n_wr}), 32'h1F);
      chk("rstmid_oe", 32'(mb.bus_data_oe), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rstmid_ready", 32'(mb.req_ready), 32'd1);
      chk("rstmid_no_rdata_en", 32'(en_cnt - en0), 32'd0);
    end
    access(1'b0, 1'b0, 1'b1, 16'h4002, 8'h00, 8'h19, 1'b0, STROBE, 1, 0);

`ifdef MSXBUS_MASTER_TIMEOUT_EN
    // Wait stuck high: abort after 100 wait cycles
    mb.bus_wait = 1'b1;
    access(1'b0, 1'b0, 1'b1, 16'h6000, 8'h00, 8'h55, 1'b0, STROBE + 100, 0, 1);
    chk("timeout_rdata", 32'(mb.rdata), 32'hFF);
    mb.bus_wait = 1'b0;
    repeat (3) @(negedge clk);
`endif

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
